// File: rtl/code_pkg.sv
// Shared types and constants for the code-pair capture sequencer.
package code_pkg;

    localparam int unsigned CODE_W = 3;
    localparam logic [CODE_W-1:0] CODE_NULL = 3'b000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FIRST   = 3'd1,
        COMPARE = 3'd2,
        SHOW    = 3'd3,
        LOCKED  = 3'd4
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// Single-flop rising-edge detector; rise_c is high for the first cycle a level input is seen high.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise_c
);

    logic d_q;
    logic d_d;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise_c = d & ~d_q;

endmodule

// File: rtl/code_pair_capture.sv
// Captures two switch codes on successive confirm presses, samples the external comparator result
// and counts consecutive mismatches. Optional lockout after repeated misses: CODE_LOCKOUT_EN.
module code_pair_capture
    import code_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned MAX_MISS    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] switch_code,
    input  logic              confirm,
    input  logic              match_bit,
    output logic [CODE_W-1:0] code_1,
    output logic [CODE_W-1:0] code_2,
    output logic              result_valid,
    output logic              result_match,
    output logic [CNT_W-1:0]  miss_count,
    output logic              busy,
    output logic              locked
);

    localparam int unsigned TIMER_W = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_1_q, code_1_d;
    logic [CODE_W-1:0]   code_2_q, code_2_d;
    logic                result_valid_q, result_valid_d;
    logic                result_match_q, result_match_d;
    logic [CNT_W-1:0]    miss_count_q, miss_count_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                busy_q, busy_d;
    logic                locked_q, locked_d;

    logic                press_c;
    logic                press_ok_c;

    rise_detect u_rise_detect (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (confirm),
        .rise_c (press_c)
    );

    // The all-zero code is reserved as "nothing entered" and never captured.
    assign press_ok_c = press_c && (switch_code != CODE_NULL);

    always_comb begin
        state_d        = state_q;
        code_1_d       = code_1_q;
        code_2_d       = code_2_q;
        result_valid_d = result_valid_q;
        result_match_d = result_match_q;
        miss_count_d   = miss_count_q;
        timer_d        = timer_q;

        case (state_q)
            IDLE: begin
                if (press_ok_c) begin
                    code_1_d = switch_code;
                    state_d  = FIRST;
                end
            end
            FIRST: begin
                if (press_ok_c) begin
                    code_2_d = switch_code;
                    state_d  = COMPARE;
                end
            end
            COMPARE: begin
                // Both codes are registered, so match_bit has settled by now.
                result_match_d = match_bit;
                result_valid_d = 1'b1;
                timer_d        = TIMER_W'(SHOW_CYCLES - 1);
                state_d        = SHOW;
                if (match_bit) begin
                    miss_count_d = '0;
                end else if (miss_count_q != {CNT_W{1'b1}}) begin
                    miss_count_d = miss_count_q + CNT_W'(1);
                end
            end
            SHOW: begin
                if (timer_q == '0) begin
                    result_valid_d = 1'b0;
                    result_match_d = 1'b0;
                    code_1_d       = '0;
                    code_2_d       = '0;
                    state_d        = IDLE;
`ifdef CODE_LOCKOUT_EN
                    if (miss_count_q >= CNT_W'(MAX_MISS)) begin
                        state_d = LOCKED;
                    end
`endif
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
`ifdef CODE_LOCKOUT_EN
            LOCKED: begin
                code_1_d       = '0;
                code_2_d       = '0;
                result_valid_d = 1'b0;
                result_match_d = 1'b0;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
`ifdef CODE_LOCKOUT_EN
        locked_d = (state_d == LOCKED);
`else
        locked_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            code_1_q       <= '0;
            code_2_q       <= '0;
            result_valid_q <= 1'b0;
            result_match_q <= 1'b0;
            miss_count_q   <= '0;
            timer_q        <= '0;
            busy_q         <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            code_1_q       <= code_1_d;
            code_2_q       <= code_2_d;
            result_valid_q <= result_valid_d;
            result_match_q <= result_match_d;
            miss_count_q   <= miss_count_d;
            timer_q        <= timer_d;
            busy_q         <= busy_d;
            locked_q       <= locked_d;
        end
    end

`ifndef CODE_LOCKOUT_EN
    // MAX_MISS only matters when lockout is built in.
    logic unused_max_miss;
    assign unused_max_miss = ^(32'(MAX_MISS));
`endif

    assign code_1       = code_1_q;
    assign code_2       = code_2_q;
    assign result_valid = result_valid_q;
    assign result_match = result_match_q;
    assign miss_count   = miss_count_q;
    assign busy         = busy_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_code_pair_capture.sv
// Directed bench for code_pair_capture; match_bit is looped back as an equality compare of the codes.
module tb_code_pair_capture;

    logic       clk;
    logic       rst_n;
    logic [2:0] switch_code;
    logic       confirm;
    logic       match_bit;
    logic [2:0] code_1;
    logic [2:0] code_2;
    logic       result_valid;
    logic       result_match;
    logic [3:0] miss_count;
    logic       busy;
    logic       locked;

    int checks;
    int failures;

    code_pair_capture #(
        .SHOW_CYCLES (4),
        .CNT_W       (4),
        .MAX_MISS    (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .switch_code  (switch_code),
        .confirm      (confirm),
        .match_bit    (match_bit),
        .code_1       (code_1),
        .code_2       (code_2),
        .result_valid (result_valid),
        .result_match (result_match),
        .miss_count   (miss_count),
        .busy         (busy),
        .locked       (locked)
    );

    // Stand-in for the same_code comparator.
    assign match_bit = (code_1 == code_2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise confirm with a code, let one edge sample it, then release.
    task automatic press(input logic [2:0] sw);
        switch_code = sw;
        confirm     = 1'b1;
        tick();
        confirm     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        confirm = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        confirm     = 1'b0;
        switch_code = 3'b000;

        // 1: reset and idle quiet period
        #3;
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("idle_outs", 32'({code_1, code_2, result_valid, result_match, miss_count, busy, locked}), 32'd0);
        end

        // 2: matching pair 5/5
        press(3'b101);
        check_eq("t2_code1", 32'(code_1), 32'd5);
        check_eq("t2_busy", 32'(busy), 32'd1);
        check_eq("t2_code2_pre", 32'(code_2), 32'd0);
        tick();
        press(3'b101);
        check_eq("t2_code2", 32'(code_2), 32'd5);
        check_eq("t2_valid_cmp", 32'(result_valid), 32'd0);
        tick();
        check_eq("t2_valid", 32'(result_valid), 32'd1);
        check_eq("t2_match", 32'(result_match), 32'd1);
        check_eq("t2_miss", 32'(miss_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t2_hold", 32'(result_valid), 32'd1);
        end
        tick();
        check_eq("t2_end_valid", 32'(result_valid), 32'd0);
        check_eq("t2_end_codes", 32'({code_1, code_2}), 32'd0);
        check_eq("t2_end_busy", 32'(busy), 32'd0);
        check_eq("t2_end_match", 32'(result_match), 32'd0);

        // 3: mismatching pair 3/6, extra press during SHOW dropped
        press(3'b011);
        tick();
        press(3'b110);
        tick();
        check_eq("t3_valid", 32'(result_valid), 32'd1);
        check_eq("t3_match", 32'(result_match), 32'd0);
        check_eq("t3_miss", 32'(miss_count), 32'd1);
        tick();
        press(3'b111);
        check_eq("t3_codes_kept", 32'({code_1, code_2}), 32'({3'd3, 3'd6}));
        tick();
        check_eq("t3_still_show", 32'(result_valid), 32'd1);
        tick();
        check_eq("t3_idle_busy", 32'(busy), 32'd0);
        check_eq("t3_idle_code1", 32'(code_1), 32'd0);
        check_eq("t3_idle_miss", 32'(miss_count), 32'd1);

        // 4: null codes ignored, held button yields one capture
        press(3'b000);
        check_eq("t4_null_idle_busy", 32'(busy), 32'd0);
        check_eq("t4_null_idle_code", 32'(code_1), 32'd0);
        tick();
        press(3'b010);
        check_eq("t4_code1", 32'(code_1), 32'd2);
        tick();
        press(3'b000);
        check_eq("t4_null_first_code2", 32'(code_2), 32'd0);
        check_eq("t4_null_first_busy", 32'(busy), 32'd1);
        tick();
        check_eq("t4_no_compare", 32'(result_valid), 32'd0);
        switch_code = 3'b010;
        confirm     = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        confirm = 1'b0;
        check_eq("t4_held_busy", 32'(busy), 32'd0);
        check_eq("t4_held_code1", 32'(code_1), 32'd0);
        check_eq("t4_held_miss", 32'(miss_count), 32'd0);
        tick();

        // 5: asynchronous reset during SHOW
        press(3'b001);
        tick();
        press(3'b001);
        tick();
        check_eq("t5_valid", 32'(result_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_outs", 32'({code_1, code_2, result_valid, result_match, miss_count, busy, locked}), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        press(3'b100);
        check_eq("t5_recapture", 32'(code_1), 32'd4);
        check_eq("t5_busy", 32'(busy), 32'd1);
        do_reset();

        // 6: three consecutive mismatches
        for (int n = 0; n < 3; n++) begin
            press(3'b001);
            tick();
            press(3'b010);
            tick();
            check_eq("t6_miss_count", 32'(miss_count), 32'(n + 1));
            for (int i = 0; i < 4; i++) tick();
        end
        check_eq("t6_miss_final", 32'(miss_count), 32'd3);
`ifdef CODE_LOCKOUT_EN
        check_eq("t6_locked", 32'(locked), 32'd1);
        check_eq("t6_busy", 32'(busy), 32'd1);
        press(3'b011);
        check_eq("t6_locked_code1", 32'(code_1), 32'd0);
        check_eq("t6_still_locked", 32'(locked), 32'd1);
`else
        check_eq("t6_locked", 32'(locked), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        press(3'b011);
        check_eq("t6_code1", 32'(code_1), 32'd3);
        check_eq("t6_not_locked", 32'(locked), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
